// File: rtl/world_triangle_reader_if.sv
// ---------------------------------------------------------------------------
// world_triangle_reader_if
// Purpose : bundles the sweep control, world RAM read port and vertex stream
//           of the world triangle reader into one interface.
// Signals : start / num_triangles   sweep request and triangle count
//           rd_en / rd_addr / rd_data  world RAM read port (1-cycle latency)
//           vtx_valid / vtx_ready     vertex stream handshake
//           vtx_x/y/z, vtx_tri, vtx_idx, vtx_last  vertex beat payload
//           busy / done               sweep status
// Modports: master = the reader itself, slave = its environment.
// ---------------------------------------------------------------------------
interface world_triangle_reader_if #(
  parameter int MAX_TRIANGLES = 4,
  parameter int COORD_W       = 32,
  parameter int ADDR_W        = $clog2(MAX_TRIANGLES*9),
  parameter int TRI_W         = $clog2(MAX_TRIANGLES+1)
);
  logic               start;
  logic [TRI_W-1:0]   num_triangles;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COORD_W-1:0] rd_data;
  logic               vtx_valid;
  logic               vtx_ready;
  logic [COORD_W-1:0] vtx_x;
  logic [COORD_W-1:0] vtx_y;
  logic [COORD_W-1:0] vtx_z;
  logic [TRI_W-1:0]   vtx_tri;
  logic [1:0]         vtx_idx;
  logic               vtx_last;
  logic               busy;
  logic               done;

  modport master (
    input  start, num_triangles, rd_data, vtx_ready,
    output rd_en, rd_addr, vtx_valid, vtx_x, vtx_y, vtx_z,
           vtx_tri, vtx_idx, vtx_last, busy, done
  );

  modport slave (
    output start, num_triangles, rd_data, vtx_ready,
    input  rd_en, rd_addr, vtx_valid, vtx_x, vtx_y, vtx_z,
           vtx_tri, vtx_idx, vtx_last, busy, done
  );
endinterface

// File: rtl/world_triangle_reader.sv
// ---------------------------------------------------------------------------
// world_triangle_reader
// Purpose : on a start pulse, sweeps the flattened world RAM triangle by
//           triangle, vertex by vertex, reading X/Y/Z per vertex and handing
//           each vertex to the raster stage on a valid/ready stream. Raises a
//           one-cycle done pulse when the triangle list is exhausted.
// Ports   : clk  system clock, rising edge
//           rst  asynchronous reset, active-high
//           bus  world_triangle_reader_if.master (control, RAM port, stream)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; latches clamped triangle count
// FETCH   | 4 cycles per vertex: reads X,Y,Z on f0..f2, captures on f1..f3
// PRESENT | vertex beat valid, held until vtx_ready
// FINISH  | done pulse, back to IDLE
// ---------------------------------------------------------------------------
module world_triangle_reader #(
  parameter int MAX_TRIANGLES = 4,
  parameter int COORD_W       = 32,
  parameter int ADDR_W        = $clog2(MAX_TRIANGLES*9),
  parameter int TRI_W         = $clog2(MAX_TRIANGLES+1)
) (
  input logic                     clk,
  input logic                     rst,
  world_triangle_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [TRI_W-1:0] TRI_MAX = TRI_W'(MAX_TRIANGLES);
  localparam logic [TRI_W-1:0] TRI_ONE = TRI_W'(1);

  state_t             state_q, state_d;
  logic [TRI_W-1:0]   count_q, count_d;
  logic [TRI_W-1:0]   tri_q, tri_d;
  logic [1:0]         vert_q, vert_d;
  logic [1:0]         fetch_q, fetch_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] z_q, z_d;

  logic [TRI_W-1:0]   num_clamped;
  logic               last_tri;
  logic [1:0]         coord;
  logic               rd_en;
  logic [ADDR_W-1:0]  addr_calc;

  assign num_clamped = (bus.num_triangles > TRI_MAX) ? TRI_MAX : bus.num_triangles;
  assign last_tri    = (tri_q == (count_q - TRI_ONE));

  // Fetch timer counts down 3..0; the coordinate being read is its complement,
  // and the terminal count (f3) is the read-free capture cycle for Z.
  assign coord = 2'd3 - fetch_q;
  assign rd_en = (state_q == FETCH) && (fetch_q != 2'd0);

  assign addr_calc = (ADDR_W'(tri_q) * ADDR_W'(9))
                   + (ADDR_W'(vert_q) * ADDR_W'(3))
                   + ADDR_W'(coord);

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_en ? addr_calc : '0;
  assign bus.vtx_valid = (state_q == PRESENT);
  assign bus.vtx_x     = x_q;
  assign bus.vtx_y     = y_q;
  assign bus.vtx_z     = z_q;
  assign bus.vtx_tri   = tri_q;
  assign bus.vtx_idx   = vert_q;
  assign bus.vtx_last  = (state_q == PRESENT) && (vert_q == 2'd2) && last_tri;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tri_q   <= '0;
      vert_q  <= '0;
      fetch_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      count_q <= count_d;
      tri_q   <= tri_d;
      vert_q  <= vert_d;
      fetch_q <= fetch_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tri_d   = tri_q;
    vert_d  = vert_q;
    fetch_d = fetch_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          count_d = num_clamped;
          tri_d   = '0;
          vert_d  = 2'd0;
          fetch_d = 2'd3;
          state_d = (num_clamped == '0) ? FINISH : FETCH;
        end
      end

      FETCH: begin
        // RAM data lags the strobe by one cycle, so capture trails reads by one.
        case (fetch_q)
          2'd2:    x_d = bus.rd_data;
          2'd1:    y_d = bus.rd_data;
          2'd0:    z_d = bus.rd_data;
          default: ;
        endcase
        if (fetch_q == 2'd0) begin
          state_d = PRESENT;
        end else begin
          fetch_d = fetch_q - 2'd1;
        end
      end

      PRESENT: begin
        if (bus.vtx_ready) begin
          fetch_d = 2'd3;
          if (vert_q != 2'd2) begin
            vert_d  = vert_q + 2'd1;
            state_d = FETCH;
          end else if (!last_tri) begin
            tri_d   = tri_q + TRI_ONE;
            vert_d  = 2'd0;
            state_d = FETCH;
          end else begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_world_triangle_reader.sv
module tb_world_triangle_reader;

  localparam int MAXT = 4;
  localparam int CW   = 32;

  logic clk = 1'b0;
  logic rst;

  world_triangle_reader_if #(.MAX_TRIANGLES(MAXT), .COORD_W(CW)) bus ();

  world_triangle_reader #(.MAX_TRIANGLES(MAXT), .COORD_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] num;
    int         n_eff;
    int         exp_beats;
    int         exp_last_addr;
  } vec_t;

  vec_t vecs [6];

  int   beats, last_addr, cyc;
  logic found;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle-by-cycle reference for a sweep of n triangles with vtx_ready high.
  // Entered at the sample point of the first cycle after the accepted start;
  // returns at the sample point of the first IDLE cycle after done.
  // Cycles inj1/inj2 drive a start pulse that must be ignored.
  task automatic run_check(input int n, input int inj1, input int inj2,
                           output int nbeats, output int laddr);
    int k, p, endc;
    logic e_en, e_valid, e_busy, e_done, e_last;
    nbeats = 0;
    laddr  = -1;
    endc   = 15*n + 2;
    bus.vtx_ready = 1'b1;
    for (int c = 1; c <= endc; c++) begin
      bus.start         = (c == inj1) || (c == inj2);
      bus.num_triangles = 3'd3;
      e_en = 0; e_valid = 0; e_busy = 0; e_done = 0; e_last = 0;
      k = 0; p = 0;
      if (c <= 15*n) begin
        k       = (c-1) / 5;
        p       = (c-1) % 5;
        e_busy  = 1;
        e_en    = (p < 3);
        e_valid = (p == 4);
        e_last  = e_valid && (k == 3*n - 1);
      end else if (c == 15*n + 1) begin
        e_busy = 1;
        e_done = 1;
      end
      check($sformatf("ctl n=%0d c=%0d {en,valid,busy,done,last}", n, c),
            {bus.rd_en, bus.vtx_valid, bus.busy, bus.done, bus.vtx_last},
            {e_en, e_valid, e_busy, e_done, e_last});
      if (e_en)
        check($sformatf("rd_addr n=%0d c=%0d", n, c), 128'(bus.rd_addr), 128'(k*3 + p));
      if (e_valid)
        check($sformatf("beat n=%0d k=%0d {x,y,z,tri,idx}", n, k),
              {bus.vtx_x, bus.vtx_y, bus.vtx_z, bus.vtx_tri, bus.vtx_idx},
              {mem[k*3], mem[k*3+1], mem[k*3+2], 3'(k/3), 2'(k%3)});
      if (bus.rd_en) laddr = int'(bus.rd_addr);
      if (bus.vtx_valid && bus.vtx_ready) nbeats++;
      if (c < endc) step();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mem[a] = 32'h1000 + a;
    // tri0: (100,100,100),(200,100,100),(100,200,100)
    mem[0] = 100; mem[1] = 100; mem[2] = 100;
    mem[3] = 200; mem[4] = 100; mem[5] = 100;
    mem[6] = 100; mem[7] = 200; mem[8] = 100;
    // tri1 vertex 2: (100,100,200)
    mem[15] = 100; mem[16] = 100; mem[17] = 200;

    vecs[0] = '{3'd1, 1, 3, 8};
    vecs[1] = '{3'd2, 2, 6, 17};
    vecs[2] = '{3'd0, 0, 0, -1};
    vecs[3] = '{3'd7, 4, 12, 35};
    vecs[4] = '{3'd4, 4, 12, 35};
    vecs[5] = '{3'd3, 3, 9, 26};

    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.num_triangles = '0;
    bus.vtx_ready     = 1'b0;
    bus.rd_data       = '0;

    #12;
    check("reset outputs zero",
          {bus.rd_en, bus.rd_addr, bus.vtx_valid, bus.vtx_x, bus.vtx_y, bus.vtx_z,
           bus.vtx_tri, bus.vtx_idx, bus.vtx_last, bus.busy, bus.done}, '0);
    step();
    rst = 1'b0;
    step();

    // Table-driven sweeps with ready tied high, back to back.
    for (int i = 0; i < 6; i++) begin
      bus.start         = 1'b1;
      bus.num_triangles = vecs[i].num;
      step();
      run_check(vecs[i].n_eff, 0, 0, beats, last_addr);
      check($sformatf("beats num=%0d", vecs[i].num), 128'(beats), 128'(vecs[i].exp_beats));
      check($sformatf("last rd_addr num=%0d", vecs[i].num),
            128'(last_addr), 128'(vecs[i].exp_last_addr));
    end

    // Backpressure: hold tri1 vertex 2 for 10 cycles.
    bus.vtx_ready     = 1'b0;
    bus.start         = 1'b1;
    bus.num_triangles = 3'd2;
    step();
    bus.start = 1'b0;
    cyc   = 1;
    found = 1'b0;
    while (!found && cyc < 100) begin
      if (bus.vtx_valid && bus.vtx_tri == 3'd1 && bus.vtx_idx == 2'd1 + 2'd1) begin
        found = 1'b1;
      end else begin
        bus.vtx_ready = bus.vtx_valid;
        step();
        cyc++;
      end
    end
    bus.vtx_ready = 1'b0;
    check("stall target reached at cycle", 128'(found ? cyc : -1), 128'(30));
    for (int s = 0; s < 10; s++) begin
      check($sformatf("stall s=%0d {valid,rd_en,busy,done,last,tri,idx}", s),
            {bus.vtx_valid, bus.rd_en, bus.busy, bus.done, bus.vtx_last, bus.vtx_tri, bus.vtx_idx},
            {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 2'd2});
      check($sformatf("stall s=%0d xyz", s),
            {bus.vtx_x, bus.vtx_y, bus.vtx_z}, {32'd100, 32'd100, 32'd200});
      step();
    end
    bus.vtx_ready = 1'b1;
    step();
    check("stall release {done,valid}", {bus.done, bus.vtx_valid}, {1'b1, 1'b0});
    step();
    check("stall release idle busy", 128'(bus.busy), 128'(0));

    // Start mid-sweep and in the done cycle must both be ignored.
    bus.start         = 1'b1;
    bus.num_triangles = 3'd1;
    step();
    run_check(1, 7, 16, beats, last_addr);
    check("beats with ignored starts", 128'(beats), 128'(3));
    bus.start         = 1'b1;
    bus.num_triangles = 3'd2;
    step();
    run_check(2, 0, 0, beats, last_addr);
    check("beats after start in idle", 128'(beats), 128'(6));
    check("last rd_addr after start in idle", 128'(last_addr), 128'(17));

    // Reset during PRESENT of tri0 vertex 1.
    bus.start         = 1'b1;
    bus.num_triangles = 3'd1;
    step();
    bus.start     = 1'b0;
    bus.vtx_ready = 1'b1;
    repeat (9) step();
    check("pre-reset {valid,tri,idx}", {bus.vtx_valid, bus.vtx_tri, bus.vtx_idx},
          {1'b1, 3'd0, 2'd1});
    rst = 1'b1;
    #1;
    check("mid-sweep reset outputs zero",
          {bus.rd_en, bus.rd_addr, bus.vtx_valid, bus.vtx_x, bus.vtx_y, bus.vtx_z,
           bus.vtx_tri, bus.vtx_idx, bus.vtx_last, bus.busy, bus.done}, '0);
    step();
    check("held reset no done", {bus.done, bus.busy}, 2'b00);
    rst = 1'b0;
    bus.start         = 1'b1;
    bus.num_triangles = 3'd1;
    step();
    run_check(1, 0, 0, beats, last_addr);
    check("beats after reset", 128'(beats), 128'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
